// File: rtl/tcdm_wr_unit_ipa.sv
// Two-lane TCDM write unit: pops 8-byte beats from per-lane rx buffers and writes them to TCDM.
// Optional build macro TCDM_WR_SKIP_EMPTY_EN: lanes whose popped strobe is all-zero skip the TCDM write.

module tcdm_wr_lane (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        busy_i,
  input  logic        restart_i,
  input  logic        pop_gnt_i,
  input  logic [31:0] pop_dat_i,
  input  logic [3:0]  pop_strb_i,
  input  logic        tcdm_gnt_i,
  output logic        pop_req_o,
  output logic        tcdm_req_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        done_nxt_o
);
  typedef enum logic [1:0] {L_WAIT_POP, L_WRITE, L_DONE} lane_e;

`ifdef TCDM_WR_SKIP_EMPTY_EN
  localparam logic SKIP_EMPTY = 1'b1;
`else
  localparam logic SKIP_EMPTY = 1'b0;
`endif

  lane_e       st_q, st_d, adv;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  strb_q, strb_d;

  always_comb begin
    adv    = st_q;
    dat_d  = dat_q;
    strb_d = strb_q;
    case (st_q)
      L_WAIT_POP: if (busy_i && pop_gnt_i) begin
        dat_d  = pop_dat_i;
        strb_d = pop_strb_i;
        adv    = (SKIP_EMPTY && (pop_strb_i == 4'b0000)) ? L_DONE : L_WRITE;
      end
      L_WRITE: if (tcdm_gnt_i) adv = L_DONE;
      default: ;
    endcase
    // done_nxt_o looks at the un-restarted transition so the beat barrier costs no cycle
    st_d = (!busy_i || restart_i) ? L_WAIT_POP : adv;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= L_WAIT_POP;
      dat_q  <= '0;
      strb_q <= '0;
    end else begin
      st_q   <= st_d;
      dat_q  <= dat_d;
      strb_q <= strb_d;
    end
  end

  assign done_nxt_o = (adv == L_DONE);
  assign pop_req_o  = busy_i && (st_q == L_WAIT_POP);
  assign tcdm_req_o = busy_i && (st_q == L_WRITE);
  assign be_o       = tcdm_req_o ? strb_q : 4'b0000;
  assign wdata_o    = tcdm_req_o ? dat_q : 32'h0;
endmodule

module tcdm_wr_unit_ipa #(
  parameter int MCHAN_LEN_WIDTH = 15,
  parameter int TCDM_ADD_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cmd_req_i,
  output logic                           cmd_gnt_o,
  input  logic [TCDM_ADD_WIDTH-1:0]      cmd_add_i,
  input  logic [MCHAN_LEN_WIDTH-1:0]     cmd_len_i,
  input  logic [1:0][31:0]               data_pop_dat_i,
  input  logic [1:0][3:0]                data_pop_strb_i,
  output logic [1:0]                     data_pop_req_o,
  input  logic [1:0]                     data_pop_gnt_i,
  output logic [1:0]                     tcdm_req_o,
  input  logic [1:0]                     tcdm_gnt_i,
  output logic [1:0][TCDM_ADD_WIDTH-1:0] tcdm_add_o,
  output logic [1:0]                     tcdm_we_o,
  output logic [1:0][3:0]                tcdm_be_o,
  output logic [1:0][31:0]               tcdm_wdata_o,
  output logic                           done_o
);
  localparam int NUM_LANES = 2;
  localparam logic [MCHAN_LEN_WIDTH:0] ONE      = 1;
  localparam logic [TCDM_ADD_WIDTH-1:0] BEAT_ADD = TCDM_ADD_WIDTH'(8);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                    state_q, state_d;
  logic [TCDM_ADD_WIDTH-1:0] base_q, base_d;
  logic [MCHAN_LEN_WIDTH:0]  beats_q, beats_d;
  logic                      done_q, done_d;
  logic                      busy, restart;
  logic [NUM_LANES-1:0]      lane_done_nxt;

  assign busy    = (state_q == S_BUSY);
  assign restart = busy && (&lane_done_nxt);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beats_d = beats_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_req_i && cmd_gnt_o) begin
        base_d  = {cmd_add_i[TCDM_ADD_WIDTH-1:3], 3'b000};
        beats_d = (({{(MCHAN_LEN_WIDTH-2){1'b0}}, cmd_add_i[2:0]} + {1'b0, cmd_len_i}) >> 3) + ONE;
        state_d = S_BUSY;
      end
      default: if (restart) begin
        base_d  = base_q + BEAT_ADD;
        beats_d = beats_q - ONE;
        if (beats_q == ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beats_q <= beats_d;
      done_q  <= done_d;
    end
  end

  // the done cycle is already IDLE but must not accept a new command
  assign cmd_gnt_o = (state_q == S_IDLE) && !done_q;
  assign done_o    = done_q;
  assign tcdm_we_o = tcdm_req_o;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tcdm_wr_lane u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .busy_i     (busy),
      .restart_i  (restart),
      .pop_gnt_i  (data_pop_gnt_i[i]),
      .pop_dat_i  (data_pop_dat_i[i]),
      .pop_strb_i (data_pop_strb_i[i]),
      .tcdm_gnt_i (tcdm_gnt_i[i]),
      .pop_req_o  (data_pop_req_o[i]),
      .tcdm_req_o (tcdm_req_o[i]),
      .be_o       (tcdm_be_o[i]),
      .wdata_o    (tcdm_wdata_o[i]),
      .done_nxt_o (lane_done_nxt[i])
    );
    assign tcdm_add_o[i] = tcdm_req_o[i] ? (base_q + TCDM_ADD_WIDTH'(4 * i)) : '0;
  end
endmodule

// File: tb/tb_tcdm_wr_unit_ipa.sv
// Bench for tcdm_wr_unit_ipa: directed command table, reset abort, then random commands vs a write scoreboard.
module tb_tcdm_wr_unit_ipa;
`ifdef TCDM_WR_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_req, cmd_gnt, done;
  logic [31:0]      cmd_add;
  logic [14:0]      cmd_len;
  logic [1:0][31:0] pop_dat, tcdm_add, tcdm_wdata;
  logic [1:0][3:0]  pop_strb, tcdm_be;
  logic [1:0]       pop_req, pop_gnt, tcdm_req, tcdm_gnt, tcdm_we;

  always #5 clk = ~clk;

  tcdm_wr_unit_ipa dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt), .cmd_add_i(cmd_add), .cmd_len_i(cmd_len),
    .data_pop_dat_i(pop_dat), .data_pop_strb_i(pop_strb), .data_pop_req_o(pop_req), .data_pop_gnt_i(pop_gnt),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add), .tcdm_we_o(tcdm_we),
    .tcdm_be_o(tcdm_be), .tcdm_wdata_o(tcdm_wdata), .done_o(done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // gmode: 0 grants high, 1 random grants, 2 lane-1 TCDM grant low in cycles 1..5
  // smode: 0 random strobes, 1 all 0xF, 2 lane 0 strobe 0 / lane 1 0xF
  typedef struct {
    logic [31:0] add;
    int          len;
    int          gmode;
    int          smode;
    int          exp_beats;
    logic [31:0] exp_base;
    int          exp_done;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  wr_t expq[2][$];

  task automatic drive_cycle(input int c, input vec_t v);
    for (int i = 0; i < 2; i++) begin
      pop_dat[i] = $urandom;
      case (v.smode)
        1: pop_strb[i] = 4'hF;
        2: pop_strb[i] = (i == 0) ? 4'h0 : 4'hF;
        default: pop_strb[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      endcase
      case (v.gmode)
        1: begin
          pop_gnt[i]  = ($urandom_range(0, 3) != 0);
          tcdm_gnt[i] = ($urandom_range(0, 2) != 0);
        end
        2: begin
          pop_gnt[i]  = 1'b1;
          tcdm_gnt[i] = (i == 0) ? 1'b1 : (c >= 6);
        end
        default: begin
          pop_gnt[i]  = 1'b1;
          tcdm_gnt[i] = 1'b1;
        end
      endcase
    end
  endtask

  task automatic accept_cmd(input logic [31:0] add, input int len, output bit ok);
    pop_gnt = '0; tcdm_gnt = '0;
    cmd_req = 1'b1; cmd_add = add; cmd_len = 15'(len);
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      if (cmd_gnt) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_req = 1'b0; cmd_add = $urandom; cmd_len = 15'($urandom);
  endtask

  task automatic run_cmd(input vec_t v);
    logic [31:0] base, a;
    int pops[2], fin[2];
    bit pend[2];
    logic [31:0] p_add[2], p_dat[2];
    logic [3:0]  p_be[2];
    int done_c, l0req;
    bit ok, base_seen;
    logic [31:0] base_obs;
    wr_t w;
    base = v.add & 32'hFFFF_FFF8;
    for (int i = 0; i < 2; i++) begin
      pops[i] = 0; fin[i] = 0; pend[i] = 0; expq[i].delete();
    end
    done_c = -1; l0req = 0; base_seen = 0; base_obs = '0;
    accept_cmd(v.add, v.len, ok);
    if (!ok) return;
    for (int c = 1; c <= 300; c++) begin
      drive_cycle(c, v);
      @(negedge clk);
      chk("we_eq_req", tcdm_we, tcdm_req);
      if (tcdm_req[0]) l0req++;
      for (int i = 0; i < 2; i++) if (pend[i]) begin
        chk("hold_req", tcdm_req[i], 1);
        chk("hold_add", tcdm_add[i], p_add[i]);
        chk("hold_be", tcdm_be[i], p_be[i]);
        chk("hold_dat", tcdm_wdata[i], p_dat[i]);
      end
      for (int i = 0; i < 2; i++) if (pop_req[i] && pop_gnt[i]) begin
        pops[i]++;
        for (int j = 0; j < 2; j++) chk("beat_barrier", fin[j] >= pops[i] - 1, 1);
        a = base + 32'(8 * (pops[i] - 1)) + 32'(4 * i);
        if (SKIP && pop_strb[i] == 4'h0) fin[i]++;
        else expq[i].push_back('{a: a, d: pop_dat[i], b: pop_strb[i]});
      end
      for (int i = 0; i < 2; i++) if (tcdm_req[i] && tcdm_gnt[i]) begin
        if (expq[i].size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = expq[i].pop_front();
          chk("wr_add", tcdm_add[i], w.a);
          chk("wr_be", tcdm_be[i], w.b);
          chk("wr_dat", tcdm_wdata[i], w.d);
          if (!base_seen) begin base_seen = 1; base_obs = tcdm_add[i] - 32'(4 * i); end
        end
        fin[i]++;
      end
      for (int i = 0; i < 2; i++) begin
        pend[i] = tcdm_req[i] && !tcdm_gnt[i];
        p_add[i] = tcdm_add[i]; p_be[i] = tcdm_be[i]; p_dat[i] = tcdm_wdata[i];
      end
      if (done) begin
        done_c = c;
        chk("gnt_in_done_cycle", cmd_gnt, 0);
        break;
      end
      @(posedge clk); #1;
    end
    if (done_c < 0) begin chk("done_timeout", 0, 1); return; end
    if (v.exp_done >= 0) chk("done_cycle", done_c, v.exp_done);
    if (base_seen) chk("base", base_obs, v.exp_base);
    else if (v.smode != 0) chk("no_write_seen", 0, 1);
    for (int i = 0; i < 2; i++) begin
      chk("pops", pops[i], v.exp_beats);
      chk("fin", fin[i], v.exp_beats);
      chk("exp_left", expq[i].size(), 0);
    end
    if (v.smode == 2) chk("skip_l0", l0req == 0, SKIP);
    @(posedge clk); #1;
    pop_gnt = '0; tcdm_gnt = '0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_pop", pop_req, 0);
    chk("idle_tcdm", tcdm_req, 0);
    chk("idle_gnt", cmd_gnt, 1);
    @(posedge clk); #1;
  endtask

  task automatic reset_abort();
    vec_t v;
    bit ok;
    int dn;
    v = '{add: 32'h0, len: 31, gmode: 0, smode: 1, exp_beats: 4, exp_base: 32'h0, exp_done: 9};
    accept_cmd(v.add, v.len, ok);
    for (int c = 1; c <= 3; c++) begin drive_cycle(c, v); @(posedge clk); #1; end
    drive_cycle(4, v);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_tcdm_req", tcdm_req, 0);
    chk("abort_pop_req", pop_req, 0);
    chk("abort_gnt", cmd_gnt, 1);
    chk("abort_done", done, 0);
    chk("abort_add", tcdm_add, 0);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1; drive_cycle(c + 10, v);
      @(negedge clk); if (done || tcdm_req != 0 || pop_req != 0) dn++;
    end
    chk("abort_no_resume", dn, 0);
    pop_gnt = '0; tcdm_gnt = '0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    tbl[0] = '{add: 32'h0000_0100, len: 15, gmode: 0, smode: 1, exp_beats: 2, exp_base: 32'h100, exp_done: 5};
    tbl[1] = '{add: 32'h0000_0103, len: 5,  gmode: 0, smode: 0, exp_beats: 2, exp_base: 32'h100, exp_done: 5};
    tbl[2] = '{add: 32'hFFFF_FFF8, len: 15, gmode: 0, smode: 1, exp_beats: 2, exp_base: 32'hFFFF_FFF8, exp_done: 5};
    tbl[3] = '{add: 32'h0000_0100, len: 15, gmode: 2, smode: 1, exp_beats: 2, exp_base: 32'h100, exp_done: 9};
    tbl[4] = '{add: 32'h0000_0200, len: 7,  gmode: 0, smode: 2, exp_beats: 1, exp_base: 32'h200, exp_done: 3};
    tbl[5] = '{add: 32'h0000_0007, len: 0,  gmode: 0, smode: 1, exp_beats: 1, exp_base: 32'h0, exp_done: 3};
    tbl[6] = '{add: 32'h0000_0000, len: 31, gmode: 0, smode: 1, exp_beats: 4, exp_base: 32'h0, exp_done: 9};
    tbl[7] = '{add: 32'h0000_0005, len: 3,  gmode: 1, smode: 0, exp_beats: 2, exp_base: 32'h0, exp_done: -1};

    rst_n = 1'b0; cmd_req = 1'b0; cmd_add = '0; cmd_len = '0;
    pop_dat = '0; pop_strb = '0; pop_gnt = '0; tcdm_gnt = '0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt", cmd_gnt, 1);
    chk("rst_pop_req", pop_req, 0);
    chk("rst_tcdm_req", tcdm_req, 0);
    chk("rst_we", tcdm_we, 0);
    chk("rst_add", tcdm_add, 0);
    chk("rst_be", tcdm_be, 0);
    chk("rst_wdata", tcdm_wdata, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_cmd(tbl[k]);
    reset_abort();
    run_cmd(tbl[0]);

    for (int k = 0; k < 25; k++) begin
      r.add   = $urandom;
      r.len   = $urandom_range(0, 40);
      r.gmode = $urandom_range(0, 1);
      r.smode = 0;
      r.exp_beats = ((r.add % 8) + r.len) / 8 + 1;
      r.exp_base  = r.add - (r.add % 8);
      r.exp_done  = (r.gmode == 0) ? 2 * r.exp_beats + 1 : -1;
      run_cmd(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tcdm_wr_unit_ipa.md
TCDM_WR_UNIT_IPA -- requirements
Module: tcdm_wr_unit_ipa

Interface
REQ-001 SHALL have parameter MCHAN_LEN_WIDTH, default 15: byte-length field width.
REQ-002 SHALL have parameter TCDM_ADD_WIDTH, default 32: TCDM address width.
REQ-003 SHALL use one clock; reset is synchronous and active-low. Ports: clk_i input 1 (clock), rst_ni input 1 (synchronous active-low reset).
REQ-004 SHALL have cmd_req_i input 1: write command valid.
REQ-005 SHALL have cmd_gnt_o output 1: command accepted.
REQ-006 SHALL have cmd_add_i input TCDM_ADD_WIDTH: TCDM start byte address.
REQ-007 SHALL have cmd_len_i input MCHAN_LEN_WIDTH: byte count minus 1.
REQ-008 SHALL have data_pop_dat_i input 2x32: per-lane rx buffer data.
REQ-009 SHALL have data_pop_strb_i input 2x4: per-lane byte strobes.
REQ-010 SHALL have data_pop_req_o output 2: per-lane pop request.
REQ-011 SHALL have data_pop_gnt_i input 2: per-lane data available; a pop occurs when req and gnt are both high.
REQ-012 SHALL have tcdm_req_o output 2, tcdm_gnt_i input 2, tcdm_add_o output 2xTCDM_ADD_WIDTH, tcdm_we_o output 2, tcdm_be_o output 2x4 and tcdm_wdata_o output 2x32: per-lane TCDM write port.
REQ-013 SHALL have done_o output 1: one-cycle pulse when a command completes.

Function
REQ-014 SHALL implement states IDLE and BUSY; cmd_gnt_o is high only in IDLE.
REQ-015 SHALL, on cmd_req_i&&cmd_gnt_o in IDLE: register base = {cmd_add_i[TCDM_ADD_WIDTH-1:3],3'b000} and beats = ((cmd_add_i[2:0]+cmd_len_i)>>3)+1, computed with MCHAN_LEN_WIDTH+1 bits with no overflow; then enter BUSY on the next cycle.
REQ-016 SHALL give each lane independent sub-states WAIT_POP, WRITE and DONE; all lanes enter WAIT_POP at the start of every beat.
REQ-017 SHALL drive data_pop_req_o[i]=1 only in WAIT_POP; on pop, data and strobe are registered and the lane enters WRITE on the next cycle.
REQ-018 SHALL, in WRITE, drive tcdm_req_o[i]=1, tcdm_we_o[i]=1, tcdm_add_o[i]=base+4*i, tcdm_be_o[i]=registered strobe and tcdm_wdata_o[i]=registered data, all stable until tcdm_gnt_i[i]; on grant the lane enters DONE.
REQ-019 SHALL complete a beat in the cycle both lanes are in DONE: base += 8 and beats -= 1; if beats was 1, pulse done_o and enter IDLE in the same transition, otherwise restart both lanes in WAIT_POP.
REQ-020 SHALL allow a grant arriving in the same cycle a request is raised, giving a minimum of 2 cycles per beat per lane (pop, write); lanes never stall each other except at the beat barrier.
REQ-021 SHALL keep tcdm_req_o, data_pop_req_o and done_o low in IDLE; tcdm_we_o is 1 whenever tcdm_req_o is 1.
REQ-022 SHALL let the base address wrap modulo 2^TCDM_ADD_WIDTH without error.
REQ-023 SHALL ignore cmd_req_i in BUSY; a new command is accepted no earlier than the cycle after done_o.

Reset
REQ-024 SHALL, when rst_ni=0 at a clock edge, enter IDLE and clear base, beats, lane states and registered data/strobes, regardless of any operation in flight.
REQ-025 SHALL drive these output values while in reset: cmd_gnt_o=1; data_pop_req_o=0; tcdm_req_o=0; tcdm_we_o=0; tcdm_add_o=0; tcdm_be_o=0; tcdm_wdata_o=0; done_o=0.
REQ-026 SHALL not complete or resume an aborted command after reset; TCDM requests are dropped even if ungranted.

Configuration
REQ-027 SHALL use the macro TCDM_WR_SKIP_EMPTY_EN.
REQ-028 SHALL, with TCDM_WR_SKIP_EMPTY_EN defined, move a lane whose popped strobe is 4'b0000 directly from WAIT_POP to DONE, with no TCDM request.
REQ-029 SHALL, with TCDM_WR_SKIP_EMPTY_EN undefined, issue every lane write including be=4'b0000.

Verification
REQ-030 SHALL cover: cmd add=0x100, len=15, gnts always high -> 2 beats; lane writes at 0x100/0x104, then 0x108/0x10C, be=0xF; done_o at cycle 5 after accept.
REQ-031 SHALL cover: cmd add=0x103, len=5 -> beats=2, base 0x100; TCDM adds 0x100, 0x104, 0x108, 0x10C with pushed strobes passed through unchanged.
REQ-032 SHALL cover: lane 1 tcdm_gnt_i held low for 4 cycles -> lane 1 add/data/be stable; lane 0 waits in DONE; base does not advance until lane 1 is granted.
REQ-033 SHALL cover: lane 0 strobe=0x0 with TCDM_WR_SKIP_EMPTY_EN defined -> no lane-0 tcdm_req; undefined -> lane-0 write with be=0x0.
REQ-034 SHALL cover: rst_ni=0 for 1 cycle mid-beat 2 of 4 -> all requests low the next cycle, cmd_gnt_o=1, no done_o; a new command then executes normally.
REQ-035 SHALL cover: cmd add=0xFFFFFFF8, len=15 -> second beat at 0x00000000/0x00000004.
